// File: rtl/ddr3_ring_sequencer_if.sv
// MIG user-interface bundle: command, write data and read return.
// master = sequencer side, slave = MIG side.
interface ddr3_ring_sequencer_if #(
    parameter int DW = 256,
    parameter int AW = 30
);
    logic            app_rdy;
    logic            app_en;
    logic [2:0]      app_cmd;
    logic [AW-1:0]   app_addr;
    logic            app_wdf_rdy;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic [DW-1:0]   app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;

    modport master (
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid,
        output app_en, app_cmd, app_addr,
        output app_wdf_wren, app_wdf_end,
        output app_wdf_data, app_wdf_mask
    );

    modport slave (
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid,
        input  app_en, app_cmd, app_addr,
        input  app_wdf_wren, app_wdf_end,
        input  app_wdf_data, app_wdf_mask
    );
endinterface

// File: rtl/ddr3_ring_sequencer.sv
// Drains NUM_CH capture FIFOs into per-channel DDR3 ring regions
// and reads bursts of one channel back into an output FIFO.
module ddr3_ring_sequencer #(
    parameter int NUM_CH       = 4,
    parameter int DW           = 256,
    parameter int AW           = 30,
    parameter int BURST_LEN    = 32,
    parameter int REGION_WORDS = 65536,
    parameter int ADDR_INC     = 8,
    parameter int CNTW         = 7,
    parameter int OB_DEPTH     = 128,
    localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OB_CNTW = $clog2(OB_DEPTH) + 1,
    localparam int PW      = $clog2(REGION_WORDS),
    localparam int FW      = PW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   calib_done,
    input  logic                   i_enable,
    input  logic [CHW-1:0]         i_rd_ch,
    input  logic                   i_ovf_clr,
    input  logic [NUM_CH*CNTW-1:0] ib_count,
    output logic [NUM_CH-1:0]      ib_re,
    input  logic [NUM_CH*DW-1:0]   ib_data,
    input  logic [NUM_CH-1:0]      ib_valid,
    output logic                   ob_we,
    output logic [DW-1:0]          ob_data,
    input  logic [OB_CNTW-1:0]     ob_count,
    ddr3_ring_sequencer_if.master  app,
    output logic [NUM_CH*FW-1:0]   o_fill,
    output logic [NUM_CH-1:0]      o_overflow,
    output logic                   o_busy
);
    localparam int BCW = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_FETCH,
        S_WR_WAIT,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_RD_DRAIN
    } state_t;

    state_t          r_state;
    logic [CHW-1:0]  r_ch;
    logic [CHW-1:0]  r_rr;
    logic            r_last_rd;
    logic [PW-1:0]   r_wr_ptr [NUM_CH];
    logic [PW-1:0]   r_rd_ptr [NUM_CH];
    logic [FW-1:0]   r_fill   [NUM_CH];
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] r_ib_re;
    logic            r_ob_we;
    logic [DW-1:0]   r_ob_data;
    logic            r_app_en;
    logic [2:0]      r_app_cmd;
    logic [AW-1:0]   r_app_addr;
    logic            r_wren;
    logic [DW-1:0]   r_wdata;
    logic            r_cmd_done;
    logic            r_dat_done;
    logic [BCW-1:0]  r_word_cnt;
    logic [BCW-1:0]  r_ret_cnt;
    logic [PW-1:0]   r_rd_cur;

    logic [NUM_CH-1:0] w_wr_elig;
    logic            w_pick_ok;
    logic [CHW-1:0]  w_pick;
    logic [CHW-1:0]  w_rr_nxt;
    int              w_idx;
    logic            w_rd_ok;
    logic            w_go;
    logic            w_do_rd;
    logic            w_do_wr;
    logic            w_cmd_acc;
    logic            w_dat_acc;
    logic            w_cmd_ok;
    logic            w_dat_ok;
    logic [DW-1:0]   w_ib_word;
    logic            w_wr_last;
    logic            w_rd_last;
    logic            w_ret_done;

    function automatic logic [AW-1:0] f_addr(
        input logic [CHW-1:0] ch,
        input logic [PW-1:0]  ptr
    );
        return AW'((64'(ch) * 64'(REGION_WORDS) + 64'(ptr))
                   * 64'(ADDR_INC));
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr_elig[g] =
            32'(ib_count[g*CNTW +: CNTW]) >= BURST_LEN;
        assign o_fill[g*FW +: FW] = r_fill[g];
    end

    // Scan from the highest offset down so the lowest offset wins.
    always_comb begin
        w_pick_ok = 1'b0;
        w_pick    = '0;
        w_idx     = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            if (w_wr_elig[CHW'(w_idx)]) begin
                w_pick_ok = 1'b1;
                w_pick    = CHW'(w_idx);
            end
        end
    end

    assign w_rr_nxt = (int'(w_pick) == NUM_CH - 1) ?
                      '0 : w_pick + CHW'(1);
    assign w_rd_ok  = (32'(i_rd_ch) < NUM_CH) &&
                      (32'(r_fill[i_rd_ch]) >= BURST_LEN) &&
                      (32'(ob_count) <= OB_DEPTH - BURST_LEN);
    assign w_go     = calib_done & i_enable;
    assign w_do_rd  = w_go & w_rd_ok & (~r_last_rd | ~w_pick_ok);
    assign w_do_wr  = w_go & w_pick_ok & ~w_do_rd;

    assign w_cmd_acc = r_app_en & app.app_rdy;
    assign w_dat_acc = r_wren & app.app_wdf_rdy;
    assign w_cmd_ok  = r_cmd_done | w_cmd_acc;
    assign w_dat_ok  = r_dat_done | w_dat_acc;
    assign w_ib_word = ib_data[int'(r_ch)*DW +: DW];
    assign w_wr_last = 32'(r_word_cnt) == BURST_LEN - 1;
    assign w_rd_last = 32'(r_word_cnt) == BURST_LEN - 1;
    assign w_ret_done = 32'(r_ret_cnt) +
                        (app.app_rd_data_valid ? 1 : 0) >= BURST_LEN;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_rr       <= '0;
            r_last_rd  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_fill[k]   <= '0;
            end
            r_ovf      <= '0;
            r_ib_re    <= '0;
            r_ob_we    <= 1'b0;
            r_ob_data  <= '0;
            r_app_en   <= 1'b0;
            r_app_cmd  <= 3'b000;
            r_app_addr <= '0;
            r_wren     <= 1'b0;
            r_wdata    <= '0;
            r_cmd_done <= 1'b0;
            r_dat_done <= 1'b0;
            r_word_cnt <= '0;
            r_ret_cnt  <= '0;
            r_rd_cur   <= '0;
        end else begin
            r_ob_we   <= app.app_rd_data_valid;
            r_ob_data <= app.app_rd_data;
            r_ib_re   <= '0;
            if (i_ovf_clr) r_ovf <= '0;
            if (app.app_rd_data_valid &&
                (r_state == S_RD_ISSUE || r_state == S_RD_DRAIN))
                r_ret_cnt <= r_ret_cnt + BCW'(1);

            unique case (r_state)
                S_IDLE: begin
                    if (w_do_rd) begin
                        r_ch       <= i_rd_ch;
                        r_last_rd  <= 1'b1;
                        r_rd_cur   <= r_rd_ptr[i_rd_ch];
                        r_rd_ptr[i_rd_ch] <=
                            r_rd_ptr[i_rd_ch] + PW'(BURST_LEN);
                        r_fill[i_rd_ch] <=
                            r_fill[i_rd_ch] - FW'(BURST_LEN);
                        r_app_en   <= 1'b1;
                        r_app_cmd  <= 3'b001;
                        r_app_addr <= f_addr(i_rd_ch,
                                             r_rd_ptr[i_rd_ch]);
                        r_word_cnt <= '0;
                        r_ret_cnt  <= '0;
                        r_state    <= S_RD_ISSUE;
                    end else if (w_do_wr) begin
                        r_ch       <= w_pick;
                        r_rr       <= w_rr_nxt;
                        r_last_rd  <= 1'b0;
                        r_word_cnt <= '0;
                        r_ib_re    <= NUM_CH'(1) << w_pick;
                        r_state    <= S_WR_FETCH;
                        // Region full: drop the oldest unread burst.
                        if (32'(r_fill[w_pick]) >
                            REGION_WORDS - BURST_LEN) begin
                            r_rd_ptr[w_pick] <=
                                r_rd_ptr[w_pick] + PW'(BURST_LEN);
                            r_fill[w_pick] <=
                                r_fill[w_pick] - FW'(BURST_LEN);
                            r_ovf[w_pick] <= 1'b1;
                        end
                    end
                end
                S_WR_FETCH: r_state <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (ib_valid[r_ch]) begin
                        r_wdata    <= w_ib_word;
                        r_app_en   <= 1'b1;
                        r_wren     <= 1'b1;
                        r_app_cmd  <= 3'b000;
                        r_app_addr <= f_addr(r_ch, r_wr_ptr[r_ch]);
                        r_cmd_done <= 1'b0;
                        r_dat_done <= 1'b0;
                        r_state    <= S_WR_ISSUE;
                    end
                end
                S_WR_ISSUE: begin
                    if (w_cmd_ok && w_dat_ok) begin
                        r_app_en   <= 1'b0;
                        r_wren     <= 1'b0;
                        r_cmd_done <= 1'b0;
                        r_dat_done <= 1'b0;
                        r_wr_ptr[r_ch] <= r_wr_ptr[r_ch] + PW'(1);
                        r_fill[r_ch]   <= r_fill[r_ch] + FW'(1);
                        r_word_cnt <= r_word_cnt + BCW'(1);
                        if (w_wr_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_ib_re <= NUM_CH'(1) << r_ch;
                            r_state <= S_WR_FETCH;
                        end
                    end else begin
                        if (w_cmd_acc) begin
                            r_app_en   <= 1'b0;
                            r_cmd_done <= 1'b1;
                        end
                        if (w_dat_acc) begin
                            r_wren     <= 1'b0;
                            r_dat_done <= 1'b1;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (w_cmd_acc) begin
                        r_rd_cur   <= r_rd_cur + PW'(1);
                        r_app_addr <= f_addr(r_ch, r_rd_cur + PW'(1));
                        r_word_cnt <= r_word_cnt + BCW'(1);
                        if (w_rd_last) begin
                            r_app_en <= 1'b0;
                            r_state  <= S_RD_DRAIN;
                        end
                    end
                end
                S_RD_DRAIN: begin
                    if (w_ret_done) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ib_re            = r_ib_re;
    assign ob_we            = r_ob_we;
    assign ob_data          = r_ob_data;
    assign app.app_en       = r_app_en;
    assign app.app_cmd      = r_app_cmd;
    assign app.app_addr     = r_app_addr;
    assign app.app_wdf_wren = r_wren;
    assign app.app_wdf_end  = r_wren;
    assign app.app_wdf_data = r_wdata;
    assign app.app_wdf_mask = '0;
    assign o_overflow       = r_ovf;
    assign o_busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_ddr3_ring_sequencer.sv
// Directed bench: FIFO and MIG behavioural models plus
// a linear sequence of checked steps.
module tb_ddr3_ring_sequencer;
    localparam int NUM_CH = 4;
    localparam int DW     = 32;
    localparam int AW     = 30;
    localparam int BL     = 32;
    localparam int RW     = 128;
    localparam int AI     = 8;
    localparam int CNTW   = 8;
    localparam int OBD    = 128;
    localparam int OBW    = 8;
    localparam int FW     = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic calib_done = 1'b0;
    logic i_enable = 1'b0;
    logic [1:0] i_rd_ch = 2'd0;
    logic i_ovf_clr = 1'b0;
    logic [NUM_CH*CNTW-1:0] ib_count;
    logic [NUM_CH-1:0] ib_re;
    logic [NUM_CH*DW-1:0] ib_data = '0;
    logic [NUM_CH-1:0] ib_valid = '0;
    logic ob_we;
    logic [DW-1:0] ob_data;
    logic [OBW-1:0] ob_count = '0;
    logic [NUM_CH*FW-1:0] o_fill;
    logic [NUM_CH-1:0] o_overflow;
    logic o_busy;

    ddr3_ring_sequencer_if #(.DW(DW), .AW(AW)) app ();

    ddr3_ring_sequencer #(
        .NUM_CH(NUM_CH), .DW(DW), .AW(AW), .BURST_LEN(BL),
        .REGION_WORDS(RW), .ADDR_INC(AI), .CNTW(CNTW),
        .OB_DEPTH(OBD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
        .i_enable(i_enable), .i_rd_ch(i_rd_ch),
        .i_ovf_clr(i_ovf_clr), .ib_count(ib_count),
        .ib_re(ib_re), .ib_data(ib_data), .ib_valid(ib_valid),
        .ob_we(ob_we), .ob_data(ob_data), .ob_count(ob_count),
        .app(app), .o_fill(o_fill), .o_overflow(o_overflow),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int pushed [NUM_CH];
    int popped [NUM_CH];
    logic [NUM_CH-1:0] re_d = '0;
    logic [DW-1:0] lat [NUM_CH];
    int unsigned wa_q [$];
    int unsigned ra_q [$];
    logic [DW-1:0] wd_q [$];
    logic [DW-1:0] ob_q [$];
    logic [DW-1:0] mem [int unsigned];
    int paired = 0;
    int end_err = 0;
    int mask_err = 0;
    int lat_err = 0;
    logic hold_rdy = 1'b0;
    logic rd_pend = 1'b0;
    logic [DW-1:0] rd_dat = '0;
    logic valid_d = 1'b0;
    int passed = 0;
    int total = 0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign ib_count[g*CNTW +: CNTW] =
            CNTW'(pushed[g] - popped[g]);
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            pushed[c] = 0;
            popped[c] = 0;
            lat[c] = '0;
        end
    end

    // FIFO and MIG models, evaluated mid-cycle.
    initial begin
        app.app_rdy = 1'b1;
        app.app_wdf_rdy = 1'b1;
        app.app_rd_data_valid = 1'b0;
        app.app_rd_data = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                ib_valid[c] = re_d[c];
                if (re_d[c]) ib_data[c*DW +: DW] = lat[c];
                re_d[c] = ib_re[c];
                if (ib_re[c]) begin
                    lat[c] = DW'((c << 24) | popped[c]);
                    popped[c] = popped[c] + 1;
                end
            end
            if (rst_n && ob_we !== valid_d) lat_err++;
            app.app_rdy = !hold_rdy;
            app.app_rd_data_valid = rst_n && rd_pend;
            app.app_rd_data = rd_pend ? rd_dat : '0;
            valid_d = app.app_rd_data_valid;
            rd_pend = 1'b0;
            if (rst_n && app.app_en && app.app_rdy) begin
                if (app.app_cmd == 3'b000) begin
                    wa_q.push_back(32'(app.app_addr));
                end else begin
                    ra_q.push_back(32'(app.app_addr));
                    rd_pend = 1'b1;
                    rd_dat = mem.exists(32'(app.app_addr)) ?
                        mem[32'(app.app_addr)] : 32'hDEAD0000;
                end
            end
            if (rst_n && app.app_wdf_wren && app.app_wdf_rdy) begin
                wd_q.push_back(app.app_wdf_data);
                if (!app.app_wdf_end) end_err++;
                if (app.app_wdf_mask != '0) mask_err++;
            end
            while (paired < wa_q.size() && paired < wd_q.size()) begin
                mem[wa_q[paired]] = wd_q[paired];
                paired++;
            end
            if (rst_n && ob_we) ob_q.push_back(ob_data);
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] fill(input int c);
        return 64'(o_fill[c*FW +: FW]);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_pairs(input int n);
        int k;
        for (k = 0; k < 8000; k++) begin
            if (paired >= n && !o_busy) break;
            tick();
        end
        check("wait_pairs_timeout", 64'(k < 8000), 64'(1));
    endtask

    task automatic wait_ob(input int n);
        int k;
        for (k = 0; k < 8000; k++) begin
            if (ob_q.size() >= n && !o_busy) break;
            tick();
        end
        check("wait_ob_timeout", 64'(k < 8000), 64'(1));
    endtask

    initial begin
        int b0;
        int r0;
        int o0;
        int s0;
        int k;
        int ptr;
        int exp_first [5];
        exp_first = '{0, 1024, 2048, 3072, 256};

        // Reset state
        do_reset();
        check("rst_app_en", 64'(app.app_en), 64'(0));
        check("rst_wren", 64'(app.app_wdf_wren), 64'(0));
        check("rst_ib_re", 64'(ib_re), 64'(0));
        check("rst_ob_we", 64'(ob_we), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_fill", 64'(o_fill), 64'(0));
        check("rst_ovf", 64'(o_overflow), 64'(0));

        // Single channel write burst then readback
        calib_done = 1'b1;
        i_enable = 1'b1;
        pushed[0] += 32;
        wait_pairs(32);
        if (paired < 32) tick();
        for (int i = 0; i < 32; i++)
            check("t1_wr_addr", 64'(wa_q[i]), 64'(i * 8));
        while (o_busy && paired >= 32 && ra_q.size() == 0 &&
               fill(0) != 32) tick();
        check("t1_fill0", fill(0), 64'(32));
        check("t1_idle_gap", 64'(o_busy), 64'(0));
        tick();
        check("t1_rd_en", 64'(app.app_en), 64'(1));
        check("t1_rd_cmd", 64'(app.app_cmd), 64'(1));
        check("t1_rd_addr", 64'(app.app_addr), 64'(0));
        wait_ob(32);
        for (int i = 0; i < 32; i++) begin
            check("t1_rd_addr_seq", 64'(ra_q[i]), 64'(i * 8));
            check("t1_ob_data", 64'(ob_q[i]), 64'(i));
        end
        check("t1_fill0_after", fill(0), 64'(0));

        // Round robin with reads blocked
        do_reset();
        check("t2_rst_fill", 64'(o_fill), 64'(0));
        ob_count = OBW'(OBD);
        b0 = wa_q.size();
        pushed[0] += 64;
        pushed[1] += 32;
        pushed[2] += 32;
        pushed[3] += 32;
        wait_pairs(b0 + 160);
        for (int b = 0; b < 5; b++)
            check("t2_burst_first",
                  64'(wa_q[b0 + 32*b]), 64'(exp_first[b]));
        check("t2_fill0", fill(0), 64'(64));
        check("t2_fill1", fill(1), 64'(32));
        check("t2_fill3", fill(3), 64'(32));

        // Command stall while data is accepted
        b0 = wa_q.size();
        r0 = wd_q.size();
        s0 = popped[1];
        hold_rdy = 1'b1;
        pushed[1] += 32;
        for (k = 0; k < 200 && wd_q.size() == r0; k++) tick();
        check("t3_data_seen", 64'(wd_q.size()), 64'(r0 + 1));
        repeat (5) tick();
        check("t3_no_cmd", 64'(wa_q.size()), 64'(b0));
        check("t3_no_dup", 64'(wd_q.size()), 64'(r0 + 1));
        check("t3_no_refetch", 64'(popped[1]), 64'(s0 + 1));
        check("t3_no_commit", fill(1), 64'(32));
        check("t3_en_held", 64'(app.app_en), 64'(1));
        hold_rdy = 1'b0;
        wait_pairs(b0 + 32);
        check("t3_pairs", 64'(wd_q.size()), 64'(wa_q.size()));
        check("t3_first_addr", 64'(wa_q[b0]), 64'(1024 + 256));
        for (int i = 0; i < 32; i++)
            check("t3_data", 64'(wd_q[r0 + i]),
                  64'((1 << 24) | (s0 + i)));
        check("t3_fill1", fill(1), 64'(64));

        // Overflow of channel 0
        do_reset();
        ob_count = OBW'(OBD);
        s0 = popped[0];
        b0 = paired;
        pushed[0] += 128;
        wait_pairs(b0 + 128);
        check("t4_fill_full", fill(0), 64'(128));
        check("t4_no_ovf", 64'(o_overflow), 64'(0));
        pushed[0] += 32;
        wait_pairs(b0 + 160);
        check("t4_ovf_set", 64'(o_overflow), 64'(1));
        check("t4_fill_cap", fill(0), 64'(128));
        check("t4_wrap_addr", 64'(wa_q[wa_q.size() - 32]), 64'(0));
        r0 = ra_q.size();
        o0 = ob_q.size();
        ob_count = '0;
        i_rd_ch = 2'd0;
        for (k = 0; k < 200 && ra_q.size() == r0; k++) tick();
        check("t4_rd_start", 64'(ra_q[r0]), 64'(32 * 8));
        wait_ob(o0 + 128);
        for (int i = 0; i < 128; i++) begin
            ptr = (32 + i) % 128;
            check("t4_ob_data", 64'(ob_q[o0 + i]),
                  64'((ptr < 32) ? s0 + 128 + ptr : s0 + ptr));
        end
        check("t4_ovf_sticky", 64'(o_overflow), 64'(1));
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        tick();
        check("t4_ovf_clr", 64'(o_overflow), 64'(0));
        check("t4_fill_empty", fill(0), 64'(0));

        // Reset during read issue
        do_reset();
        pushed[0] += 32;
        for (k = 0; k < 2000; k++) begin
            if (app.app_en && app.app_cmd == 3'b001) break;
            tick();
        end
        check("t5_rd_seen", 64'(k < 2000), 64'(1));
        repeat (3) tick();
        check("t5_mid_busy", 64'(o_busy), 64'(1));
        rst_n = 1'b0;
        tick();
        check("t5_app_en", 64'(app.app_en), 64'(0));
        check("t5_ob_we", 64'(ob_we), 64'(0));
        check("t5_fill", fill(0), 64'(0));
        check("t5_busy", 64'(o_busy), 64'(0));
        rst_n = 1'b1;
        repeat (3) tick();

        check("wdf_end_tracks", 64'(end_err), 64'(0));
        check("wdf_mask_zero", 64'(mask_err), 64'(0));
        check("ob_latency", 64'(lat_err), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
